// File: rtl/rv32i_imem_if.sv
// Wishbone pipelined instruction-fetch bus between the fetch responder (master) and memory (slave).
interface rv32i_imem_if;
    logic        cyc;
    logic        stb;
    logic [31:0] addr;
    logic        stall;
    logic        ack;
    logic [31:0] data;

    modport master (output cyc, stb, addr, input stall, ack, data);
    modport slave  (input cyc, stb, addr, output stall, ack, data);
endinterface

// File: rtl/rv32i_imem_responder.sv
// One-entry instruction buffer in front of a Wishbone bus: stalls fetch on a miss,
// issues a single outstanding read, and substitutes NOP_INST when the bus times out.
module rv32i_imem_responder #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [31:0]         i_iaddr,
    output logic [31:0]         o_inst,
    output logic                o_stall,
    input  logic                i_flush,
    output logic                o_fault,
    rv32i_imem_if.master        wb
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

    state_t           r_state;
    logic             r_buf_vld;
    logic [31:2]      r_buf_addr;
    logic [31:0]      r_buf_data;
    logic [31:2]      r_req_addr;
    logic             r_discard;
    logic [CNT_W-1:0] r_cnt;
    logic             r_fault;
    logic             r_cyc;
    logic             r_stb;
    logic [31:0]      r_addr;

    logic w_hit;
    logic w_busy;
    logic w_timeout;
    logic w_unused;

    // Fetch addresses are word granular; the byte offset is deliberately dropped.
    assign w_unused = ^i_iaddr[1:0];

    assign w_hit     = r_buf_vld && (r_buf_addr == i_iaddr[31:2]);
    assign w_busy    = (r_state != ST_IDLE);
    assign w_timeout = w_busy && !wb.ack && (r_cnt == CNT_W'(TIMEOUT - 1));

    assign o_stall = !w_hit;
    assign o_inst  = r_buf_data;
    assign o_fault = r_fault;
    assign wb.cyc  = r_cyc;
    assign wb.stb  = r_stb;
    assign wb.addr = r_addr;

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_buf_vld  <= 1'b0;
            r_buf_addr <= '0;
            // NOTE: buffer data is reset too, because o_inst must read zero while in reset.
            r_buf_data <= '0;
            r_req_addr <= '0;
            r_discard  <= 1'b0;
            r_cnt      <= '0;
            r_fault    <= 1'b0;
            r_cyc      <= 1'b0;
            r_stb      <= 1'b0;
            r_addr     <= '0;
        end else begin
            r_fault <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_flush) begin
                        r_buf_vld <= 1'b0;
                    end else if (!w_hit) begin
                        r_req_addr <= i_iaddr[31:2];
                        r_addr     <= {i_iaddr[31:2], 2'b00};
                        r_cyc      <= 1'b1;
                        r_stb      <= 1'b1;
                        r_cnt      <= '0;
                        r_discard  <= 1'b0;
                        r_state    <= ST_REQ;
                    end
                end
                ST_REQ, ST_WAIT: begin
                    if (wb.ack || w_timeout) begin
                        r_state   <= ST_IDLE;
                        r_cyc     <= 1'b0;
                        r_stb     <= 1'b0;
                        r_discard <= 1'b0;
                        r_fault   <= w_timeout;
                        // A flush seen now or earlier in this request drops the response.
                        if (r_discard || i_flush) begin
                            r_buf_vld <= 1'b0;
                        end else begin
                            r_buf_vld  <= 1'b1;
                            r_buf_addr <= r_req_addr;
                            r_buf_data <= wb.ack ? wb.data : NOP_INST;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (i_flush) begin
                            r_buf_vld <= 1'b0;
                            r_discard <= 1'b1;
                        end
                        if (r_state == ST_REQ && !wb.stall) begin
                            r_stb   <= 1'b0;
                            r_state <= ST_WAIT;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cyc   <= 1'b0;
                    r_stb   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rv32i_imem_responder.sv
// Directed bench for rv32i_imem_responder: bus responses go into a scoreboard and are
// compared when the fetch side sees the instruction; a second instance covers timeouts.
module tb_rv32i_imem_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rst2_n = 1'b0;
    logic [31:0] iaddr = 32'h0;
    logic [31:0] iaddr2 = 32'h40;
    logic        flush = 1'b0;
    logic        flush2 = 1'b0;
    logic [31:0] inst, inst2;
    logic        stall, stall2;
    logic        fault, fault2;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } sb_item_t;

    sb_item_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;

    rv32i_imem_if bus ();
    rv32i_imem_if bus2 ();

    rv32i_imem_responder dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_iaddr (iaddr),
        .o_inst  (inst),
        .o_stall (stall),
        .i_flush (flush),
        .o_fault (fault),
        .wb      (bus)
    );

    rv32i_imem_responder #(.TIMEOUT(4), .NOP_INST(32'h0000_0013)) dut4 (
        .i_clk   (clk),
        .i_rst_n (rst2_n),
        .i_iaddr (iaddr2),
        .o_inst  (inst2),
        .o_stall (stall2),
        .i_flush (flush2),
        .o_fault (fault2),
        .wb      (bus2)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present read data on the bus for one cycle and record what fetch should later see.
    task automatic respond(input logic [31:0] addr, input logic [31:0] data);
        sb_item_t it;
        bus.ack  = 1'b1;
        bus.data = data;
        it.addr  = addr;
        it.data  = data;
        sb.push_back(it);
        tick();
        bus.ack  = 1'b0;
        bus.data = 32'h0;
    endtask

    task automatic expect_fetch(input string tag);
        sb_item_t it;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s: observed empty scoreboard expected pending response", tag);
        end else begin
            it = sb.pop_front();
            iaddr = it.addr;
            #1;
            check({tag, "_stall"}, {31'b0, stall}, 32'h0);
            check({tag, "_inst"}, inst, it.data);
        end
    endtask

    task automatic check_req(input string tag, input logic [31:0] addr);
        check({tag, "_cyc"}, {31'b0, bus.cyc}, 32'h1);
        check({tag, "_stb"}, {31'b0, bus.stb}, 32'h1);
        check({tag, "_addr"}, bus.addr, addr);
    endtask

    initial begin
        bus.stall  = 1'b0;
        bus.ack    = 1'b0;
        bus.data   = 32'h0;
        bus2.stall = 1'b0;
        bus2.ack   = 1'b0;
        bus2.data  = 32'h0;

        // Reset state
        tick();
        tick();
        check("rst_stall", {31'b0, stall}, 32'h1);
        check("rst_inst", inst, 32'h0);
        check("rst_cyc", {31'b0, bus.cyc}, 32'h0);
        check("rst_stb", {31'b0, bus.stb}, 32'h0);
        check("rst_addr", bus.addr, 32'h0);
        check("rst_fault", {31'b0, fault}, 32'h0);
        rst_n = 1'b1;

        // Zero-wait fetch at 0x0: stb at T+1, ack at T+2, instruction at T+3
        check("zw_t0_stb", {31'b0, bus.stb}, 32'h0);
        tick();
        check_req("zw_t1", 32'h0);
        tick();
        check("zw_t2_stb", {31'b0, bus.stb}, 32'h0);
        check("zw_t2_cyc", {31'b0, bus.cyc}, 32'h1);
        check("zw_t2_stall", {31'b0, stall}, 32'h1);
        respond(32'h0, 32'h0050_0093);
        check("zw_t3_cyc", {31'b0, bus.cyc}, 32'h0);
        expect_fetch("zw_t3");

        // Back-pressure at 0x4: stb and address held four cycles, one accept
        iaddr = 32'h4;
        #1;
        check("bp_miss", {31'b0, stall}, 32'h1);
        tick();
        bus.stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_req($sformatf("bp_hold%0d", i), 32'h4);
            if (i == 3) bus.stall = 1'b0;
            tick();
        end
        check("bp_wait_stb", {31'b0, bus.stb}, 32'h0);
        check("bp_wait_cyc", {31'b0, bus.cyc}, 32'h1);
        respond(32'h4, 32'h0010_0113);
        expect_fetch("bp_done");

        // Redirect 0x8 -> 0x100 while waiting: response still lands tagged 0x8
        iaddr = 32'h8;
        tick();
        check_req("rd_req8", 32'h8);
        tick();
        iaddr = 32'h100;
        #1;
        check("rd_wait_stall", {31'b0, stall}, 32'h1);
        respond(32'h8, 32'h0080_0193);
        check("rd_after_stall", {31'b0, stall}, 32'h1);
        expect_fetch("rd_tag8");
        iaddr = 32'h100;
        tick();
        check_req("rd_req100", 32'h100);
        tick();
        respond(32'h100, 32'h1000_0213);
        expect_fetch("rd_100");

        // Flush while waiting at 0xC: the response is dropped and refetched
        iaddr = 32'hC;
        tick();
        check_req("fw_req", 32'hC);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bus.ack  = 1'b1;
        bus.data = 32'hDEAD_BEEF;
        tick();
        bus.ack  = 1'b0;
        check("fw_cyc", {31'b0, bus.cyc}, 32'h0);
        check("fw_stall", {31'b0, stall}, 32'h1);
        tick();
        check_req("fw_rereq", 32'hC);
        tick();
        respond(32'hC, 32'h00C0_0293);
        expect_fetch("fw_done");

        // Flush in the same cycle as ack: response discarded
        iaddr = 32'h20;
        tick();
        tick();
        flush    = 1'b1;
        bus.ack  = 1'b1;
        bus.data = 32'hBAD0_0001;
        tick();
        flush    = 1'b0;
        bus.ack  = 1'b0;
        check("fa_stall", {31'b0, stall}, 32'h1);
        check("fa_cyc", {31'b0, bus.cyc}, 32'h0);
        tick();
        check_req("fa_rereq", 32'h20);
        tick();
        respond(32'h20, 32'h0200_0313);
        expect_fetch("fa_done");

        // Flush in IDLE invalidates; refetch completes with an ack during REQ
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fi_stall", {31'b0, stall}, 32'h1);
        tick();
        check_req("fi_req", 32'h20);
        respond(32'h20, 32'h0200_0393);
        check("fi_cyc", {31'b0, bus.cyc}, 32'h0);
        expect_fetch("fi_reqack");

        // Unaligned address 0x13: request at 0x10, hits for 0x10..0x13
        iaddr = 32'h13;
        tick();
        check_req("ua_req", 32'h10);
        tick();
        respond(32'h13, 32'h0130_0413);
        expect_fetch("ua_done");
        for (int a = 16; a < 20; a++) begin
            iaddr = 32'(a);
            #1;
            check($sformatf("ua_hit%0d", a), {31'b0, stall}, 32'h0);
        end
        iaddr = 32'h14;
        #1;
        check("ua_miss14", {31'b0, stall}, 32'h1);
        iaddr = 32'h13;
        #1;

        // Late ack in IDLE is ignored
        bus.ack  = 1'b1;
        bus.data = 32'hBAD0_0002;
        tick();
        bus.ack  = 1'b0;
        check("late_inst", inst, 32'h0130_0413);
        check("late_stall", {31'b0, stall}, 32'h0);
        check("late_cyc", {31'b0, bus.cyc}, 32'h0);

        // Reset mid-request abandons it; the following ack in IDLE is ignored
        iaddr = 32'h200;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("mr_cyc", {31'b0, bus.cyc}, 32'h0);
        check("mr_stb", {31'b0, bus.stb}, 32'h0);
        check("mr_addr", bus.addr, 32'h0);
        check("mr_stall", {31'b0, stall}, 32'h1);
        check("mr_inst", inst, 32'h0);
        tick();
        rst_n    = 1'b1;
        bus.ack  = 1'b1;
        bus.data = 32'hBAD0_0003;
        tick();
        bus.ack  = 1'b0;
        check("mr_nowrite", {31'b0, stall}, 32'h1);
        check_req("mr_rereq", 32'h200);
        tick();
        respond(32'h200, 32'h2000_0493);
        expect_fetch("mr_done");

        // Timeout with TIMEOUT=4: cyc for four cycles, one fault pulse, NOP returned
        rst2_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("to_cyc%0d", i), {31'b0, bus2.cyc}, 32'h1);
            check($sformatf("to_nofault%0d", i), {31'b0, fault2}, 32'h0);
            tick();
        end
        check("to_cyc_drop", {31'b0, bus2.cyc}, 32'h0);
        check("to_fault", {31'b0, fault2}, 32'h1);
        check("to_stall", {31'b0, stall2}, 32'h0);
        check("to_inst", inst2, 32'h0000_0013);
        tick();
        check("to_fault_end", {31'b0, fault2}, 32'h0);
        check("to_idle", {31'b0, bus2.cyc}, 32'h0);

        check("sb_drained", 32'(sb.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rv32i_imem_responder.md
RV32I_IMEM_RESPONDER -- requirements
Module: rv32i_imem_responder

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum bus cycles per request before abort; legal range 1..65535.
REQ-002 Parameter NOP_INST, default 32'h0000_0013: instruction returned on timeout.
REQ-003 i_clk  input  1  clock; all state changes on its rising edge.
REQ-004 i_rst_n  input  1  reset; asynchronous, active-low.
REQ-005 i_iaddr  input  32  fetch-stage instruction address; bits [1:0] are ignored.
REQ-006 o_inst  output  32  instruction for i_iaddr; valid only when o_stall=0.
REQ-007 o_stall  output  1  high while the instruction for i_iaddr is not available; drives the fetch-stage stall bit.
REQ-008 i_flush  input  1  invalidates the buffer (fence.i); discards any in-flight response.
REQ-009 o_fault  output  1  one-cycle pulse when a request times out.
REQ-010 o_wb_cyc, o_wb_stb  output  1 each  bus cycle and strobe, Wishbone pipelined.
REQ-011 o_wb_addr  output  32  word-aligned request address, {addr[31:2],2'b00}.
REQ-012 i_wb_stall  input  1  bus not accepting the strobe this cycle.
REQ-013 i_wb_ack  input  1  response valid.
REQ-014 i_wb_data  input  32  response data.

Function
REQ-015 The block SHALL hold a one-entry buffer: buf_vld, buf_addr[31:2], buf_data[31:0].
REQ-016 Hit = buf_vld && buf_addr == i_iaddr[31:2]; o_stall = !hit and o_inst = buf_data, both combinational from the current i_iaddr.
REQ-017 FSM states SHALL be IDLE, REQ and WAIT.
REQ-018 IDLE: on a miss with i_flush=0, latch req_addr=i_iaddr[31:2] and go to REQ next cycle; a hit or flush stays in IDLE.
REQ-019 REQ: o_wb_cyc=1, o_wb_stb=1, o_wb_addr from req_addr; stb and address held stable while i_wb_stall=1; on accept (!i_wb_stall) go to WAIT.
REQ-020 WAIT: o_wb_cyc=1, o_wb_stb=0; remain until i_wb_ack.
REQ-021 An i_wb_ack in REQ (same-cycle accept) or in WAIT SHALL complete the request.
REQ-022 On completion: write buf_data=i_wb_data, buf_addr=req_addr, buf_vld=1; return to IDLE with o_wb_cyc=0 next cycle.
REQ-023 Zero-wait bus: a miss at cycle T gives REQ at T+1, ack at T+2 and o_stall=0 at T+3, provided i_iaddr is unchanged.
REQ-024 If i_iaddr changes during REQ/WAIT (redirect), the request SHALL still complete into the buffer tagged req_addr. The resulting miss starts a new request from IDLE; there is no mid-request abort on the bus.
REQ-025 i_flush in IDLE: buf_vld=0 next cycle.
REQ-026 i_flush in REQ/WAIT: buf_vld=0, set a discard flag, and let the bus cycle finish normally. The completing response is not written, and buf_vld stays 0.
REQ-027 i_flush in the same cycle as i_wb_ack: the response SHALL be discarded.
REQ-028 A timeout counter SHALL clear on entry to REQ and increment each cycle in REQ/WAIT without ack. Its width is $clog2(TIMEOUT+1); it SHALL not wrap.
REQ-029 When the counter reaches TIMEOUT without ack:
- drop o_wb_cyc/o_wb_stb next cycle and go to IDLE;
- write buf_data=NOP_INST, buf_addr=req_addr, buf_vld=1, unless the discard flag is set;
- pulse o_fault for exactly one cycle.
REQ-030 A late i_wb_ack arriving in IDLE SHALL be ignored.
REQ-031 Only one request SHALL be outstanding; o_wb_stb SHALL never be high outside REQ.

Reset
REQ-032 Asynchronous reset SHALL force: state=IDLE, buf_vld=0, discard=0, counter=0, o_wb_cyc=0, o_wb_stb=0, o_wb_addr=0, o_fault=0.
REQ-033 During reset o_stall=1 (buffer invalid) and o_inst=buf_data, which resets to 0.
REQ-034 Reset asserted mid-request SHALL abandon it with no buffer write; a subsequent ack in IDLE is ignored per REQ-030.

Verification
REQ-035 Zero-wait fetch: i_iaddr=0x0, bus returns 0x00500093 one cycle after accept -> stb at T+1, o_stall=0 and o_inst=0x00500093 at T+3.
REQ-036 Bus back-pressure: i_wb_stall=1 for 3 cycles at i_iaddr=0x4 -> stb and o_wb_addr=0x4 held stable for 4 cycles, then one accept and completion on ack.
REQ-037 Redirect mid-request: i_iaddr 0x8 -> 0x100 while in WAIT -> buffer tagged 0x8, o_stall stays 1, a new request for 0x100 follows, and it returns its data.
REQ-038 Flush in WAIT at 0xC, then ack -> buf_vld=0, o_stall=1, and a new request for 0xC is issued.
REQ-039 No ack with TIMEOUT=4 -> cyc drops after 4 cycles, o_fault pulses one cycle, and o_inst=0x00000013 with o_stall=0.
REQ-040 Unaligned i_iaddr=0x13 -> o_wb_addr=0x10, and a hit for 0x10..0x13.
